// File: rtl/ds_window_addr_gen.sv
// ============================================================================
// Module   : ds_window_addr_gen
// Purpose  : 2x2 down-sampling read-address generator; emits the four
//            window addresses per output pixel over valid/ready.
// Options  : DS_EDGE_CLAMP_EN - include odd trailing column/row (clamped)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ds_window_addr_gen #(
    parameter int AW    = 18,
    parameter int DIM_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] width_in,
    input  logic [DIM_W-1:0] height_in,
    input  logic [AW-1:0]    base_in,
    output logic [AW-1:0]    addr,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic [1:0]       phase,
    output logic             busy,
    output logic             done
);

    // Row/column counters carry two spare bits so +2 never overflows.
    localparam int XW = DIM_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_EMIT  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] w_q, w_d;
    logic [DIM_W-1:0] h_q, h_d;
    logic [XW-1:0]    row_q, row_d;
    logic [XW-1:0]    col_q, col_d;
    logic [AW-1:0]    row_base_q, row_base_d;
    logic [1:0]       phase_q, phase_d;

    logic [XW-1:0]    w_w_ext;
    logic [XW-1:0]    w_h_ext;
    logic [XW-1:0]    w_col_nx;
    logic [XW-1:0]    w_row_nx;
    logic             w_degenerate;
    logic             w_col_wrap;
    logic             w_row_end;
    logic             w_c_step;
    logic             w_r_step;
    logic [AW-1:0]    w_w_addr;
    logic [AW-1:0]    w_col_addr;
    logic [AW-1:0]    w_c_off;
    logic [AW-1:0]    w_r_off;
    logic [AW-1:0]    w_addr_calc;

    assign w_w_ext  = XW'(w_q);
    assign w_h_ext  = XW'(h_q);
    assign w_col_nx = col_q + XW'(2);
    assign w_row_nx = row_q + XW'(2);

`ifdef DS_EDGE_CLAMP_EN
    assign w_degenerate = (w_w_ext == '0) || (w_h_ext == '0);
    assign w_col_wrap   = (w_col_nx >= w_w_ext);
    assign w_row_end    = (w_row_nx >= w_h_ext);
    // A neighbour index that lands on W (or H) is folded back onto c (or r).
    assign w_c_step     = ((col_q + XW'(1)) != w_w_ext);
    assign w_r_step     = ((row_q + XW'(1)) != w_h_ext);
`else
    assign w_degenerate = (w_w_ext < XW'(2)) || (w_h_ext < XW'(2));
    assign w_col_wrap   = ((w_col_nx + XW'(1)) >= w_w_ext);
    assign w_row_end    = ((w_row_nx + XW'(1)) >= w_h_ext);
    assign w_c_step     = 1'b1;
    assign w_r_step     = 1'b1;
`endif

    assign w_w_addr    = AW'(w_q);
    assign w_col_addr  = AW'(col_q);
    assign w_c_off     = w_c_step ? AW'(1) : '0;
    assign w_r_off     = w_r_step ? w_w_addr : '0;
    // phase[1] selects the lower row, phase[0] the right column.
    assign w_addr_calc = row_base_q + w_col_addr
                       + (phase_q[1] ? w_r_off : '0)
                       + (phase_q[0] ? w_c_off : '0);

    assign addr_valid = (state_q == ST_EMIT);
    assign addr       = addr_valid ? w_addr_calc : '0;
    assign phase      = phase_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        phase_d    = phase_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_d        = width_in;
                    h_d        = height_in;
                    row_base_d = base_in;
                    row_d      = '0;
                    col_d      = '0;
                    phase_d    = 2'd0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                phase_d = 2'd0;
                state_d = w_degenerate ? ST_FIN : ST_EMIT;
            end
            ST_EMIT: begin
                if (addr_ready) begin
                    if (phase_q != 2'd3) begin
                        phase_d = phase_q + 2'd1;
                    end else begin
                        phase_d = 2'd0;
                        if (w_col_wrap) begin
                            col_d      = '0;
                            row_d      = w_row_nx;
                            row_base_d = row_base_q + (w_w_addr << 1);
                            if (w_row_end) begin
                                state_d = ST_FIN;
                            end
                        end else begin
                            col_d = w_col_nx;
                        end
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State advances on the falling edge to line up with the register file.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            phase_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            phase_q    <= phase_d;
        end
    end

endmodule

`default_nettype wire
